// File: rtl/conv_datapath.sv
// conv_datapath
//   Datapath of the 4x4 image convolution engine (2x2 kernel, stride 1, no padding).
//   The result is 3x3, one value per window.
//   The engine is driven by the one-hot strobes T[8:0] from the external control sequencer.
//   E tells the sequencer that the current window is the last one.
//
//   Ports
//     clk, reset            rising-edge clock, synchronous active-high reset
//     T[15:0]               one-hot timing strobes (T0..T8 used)
//     E                     last-window flag (win_idx == 8)
//     pix_we/addr/data      image store write port (addr = row*4+col)
//     k_we/addr/data        kernel store write port (tap = row*2+col)
//     res_addr/res_data     combinational result store read port (0 beyond index 8)
//     out_valid/idx/data    streamed result, one-cycle pulse per window
//     frame_done            one-cycle pulse after T8
module conv_datapath #(
  parameter int PIX_W = 4,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      T,
  output logic             E,
  input  logic             pix_we,
  input  logic [3:0]       pix_addr,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             k_we,
  input  logic [1:0]       k_addr,
  input  logic [PIX_W-1:0] k_data,
  input  logic [3:0]       res_addr,
  output logic [ACC_W-1:0] res_data,
  output logic             out_valid,
  output logic [3:0]       out_idx,
  output logic [ACC_W-1:0] out_data,
  output logic             frame_done
);

  logic [PIX_W-1:0]   pix_mem [16];
  logic [PIX_W-1:0]   k_mem   [4];
  logic [ACC_W-1:0]   res_mem [9];

  logic [3:0]         win_idx;
  logic [ACC_W-1:0]   acc;

  logic               t_valid;
  logic [8:0]         s;
  logic [1:0]         tap;
  logic [3:0]         base;
  logic [3:0]         paddr;
  logic [2*PIX_W-1:0] prod;

  // Anything other than exactly one of T0..T8 is treated as "do nothing".
  always_comb begin
    t_valid = (T != 16'd0) && ((T & (T - 16'd1)) == 16'd0) && (T[15:9] == 7'd0);
    s       = t_valid ? T[8:0] : 9'd0;
  end

  // T2..T5 walk taps 0..3; tap bit 1 steps a row (+4), tap bit 0 steps a column (+1).
  always_comb begin
    tap = 2'd0;
    if (s[3])      tap = 2'd1;
    else if (s[4]) tap = 2'd2;
    else if (s[5]) tap = 2'd3;

    // Top-left pixel of window w: (w/3)*4 + w%3.
    case (win_idx)
      4'd0:    base = 4'd0;
      4'd1:    base = 4'd1;
      4'd2:    base = 4'd2;
      4'd3:    base = 4'd4;
      4'd4:    base = 4'd5;
      4'd5:    base = 4'd6;
      4'd6:    base = 4'd8;
      4'd7:    base = 4'd9;
      4'd8:    base = 4'd10;
      default: base = 4'd0;
    endcase

    paddr = base + {1'b0, tap[1], 1'b0, tap[0]};
    prod  = {{PIX_W{1'b0}}, pix_mem[paddr]} * {{PIX_W{1'b0}}, k_mem[tap]};
  end

  assign E = (win_idx == 4'd8);

  always_comb begin
    res_data = '0;
    if (res_addr <= 4'd8) res_data = res_mem[res_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_idx    <= 4'd0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_idx    <= 4'd0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (s[0]) begin
        win_idx <= 4'd0;
        acc     <= '0;
      end
      if (s[1]) acc <= '0;
      if (|s[5:2]) acc <= acc + ACC_W'(prod);
      if (s[6]) begin
        out_data  <= acc;
        out_idx   <= win_idx;
        out_valid <= 1'b1;
      end
      if (s[7]) win_idx <= (win_idx == 4'd8) ? 4'd0 : win_idx + 4'd1;
      if (s[8]) frame_done <= 1'b1;
    end
  end

  // Storage is never cleared; image/kernel writes are honoured even in reset.
  always_ff @(posedge clk) begin
    if (pix_we) pix_mem[pix_addr] <= pix_data;
    if (k_we)   k_mem[k_addr]     <= k_data;
    if (s[6] && !reset && (win_idx <= 4'd8)) res_mem[win_idx] <= acc;
  end

endmodule

// File: tb/tb_conv_datapath.sv
module tb_conv_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] T;
  logic        E;
  logic        pix_we;
  logic [3:0]  pix_addr;
  logic [3:0]  pix_data;
  logic        k_we;
  logic [1:0]  k_addr;
  logic [3:0]  k_data;
  logic [3:0]  res_addr;
  logic [9:0]  res_data;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic [9:0]  out_data;
  logic        frame_done;

  conv_datapath dut (
    .clk(clk), .reset(reset), .T(T), .E(E),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
    .res_addr(res_addr), .res_data(res_data),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Behavioural model state
  int   img [16];
  int   ker [4];
  int   frame_exp [9];
  int   exp_res [9];
  int   cur_win = 0;
  logic exp_valid = 1'b0;
  logic exp_done  = 1'b0;
  int   exp_idx   = 0;
  int   exp_data  = 0;
  bit   started   = 1'b0;
  int   vcount    = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv)
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    else
      passed++;
  endfunction

  // Convolution computed directly from the image/kernel as they stand now.
  function automatic void compute_frame();
    for (int w = 0; w < 9; w++) begin
      int r = w / 3;
      int c = w % 3;
      frame_exp[w] = 0;
      for (int t = 0; t < 4; t++)
        frame_exp[w] += img[(r + t / 2) * 4 + c + t % 2] * ker[t];
    end
  endfunction

  // Apply one cycle of inputs, then update the model for the edge that ends it.
  task automatic step(input logic [15:0] tv, input logic rst);
    T = tv;
    reset = rst;
    @(posedge clk);
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (rst) begin
      cur_win  = 0;
      exp_idx  = 0;
      exp_data = 0;
    end else if (tv == 16'h0001) begin
      cur_win = 0;
    end else if (tv == 16'h0040) begin
      exp_valid        = 1'b1;
      exp_idx          = cur_win;
      exp_data         = frame_exp[cur_win];
      exp_res[cur_win] = frame_exp[cur_win];
    end else if (tv == 16'h0080) begin
      cur_win = (cur_win == 8) ? 0 : cur_win + 1;
    end else if (tv == 16'h0100) begin
      exp_done = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic wr_pix(input int a, input int v, input logic [15:0] tv, input logic rst);
    pix_we = 1'b1; pix_addr = 4'(a); pix_data = 4'(v);
    step(tv, rst);
    pix_we = 1'b0;
    img[a] = v;
  endtask

  task automatic wr_k(input int a, input int v, input logic rst);
    k_we = 1'b1; k_addr = 2'(a); k_data = 4'(v);
    step(16'h0000, rst);
    k_we = 1'b0;
    ker[a] = v;
  endtask

  // mode 0: constant pv everywhere; mode 1: pixel[a]=a
  task automatic load(input int mode, input int pv, input int k0, input int k1,
                      input int k2, input int k3, input logic rst);
    for (int a = 0; a < 16; a++) wr_pix(a, (mode == 1) ? a : pv, 16'h0000, rst);
    wr_k(0, k0, rst); wr_k(1, k1, rst); wr_k(2, k2, rst); wr_k(3, k3, rst);
  endtask

  task automatic chk_res(input int a, input int expv);
    res_addr = 4'(a);
    #1;
    chk("res_data", 32'(res_data), 32'(expv));
  endtask

  task automatic res_all();
    for (int a = 0; a < 16; a++) chk_res(a, (a <= 8) ? exp_res[a] : 0);
  endtask

  task automatic run_frame(input bit glitch, input bit wr6);
    int e_cnt = 0;
    compute_frame();
    vcount = 0;
    step(16'h0001, 1'b0);
    for (int w = 0; w < 9; w++) begin
      for (int s = 1; s <= 7; s++) begin
        if (s == 7 && E) e_cnt++;
        if (wr6 && w == 0 && s == 2) wr_pix(0, 7, 16'h0004, 1'b0);
        else step(16'h0001 << s, 1'b0);
        if (glitch && w == 2 && s == 3) begin
          step(16'h0000, 1'b0);
          step(16'h0018, 1'b0);
          step(16'h0200, 1'b0);
        end
      end
    end
    step(16'h0100, 1'b0);
    step(16'h0000, 1'b0);
    chk("e_in_t7_count", 32'(e_cnt), 32'd1);
    chk("pulse_count", 32'(vcount), 32'd9);
  endtask

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("frame_done", 32'(frame_done), 32'(exp_done));
        chk("out_idx", 32'(out_idx), 32'(exp_idx));
        chk("out_data", 32'(out_data), 32'(exp_data));
        chk("E", 32'(E), (cur_win == 8) ? 32'd1 : 32'd0);
        if (out_valid) vcount++;
      end
    end
  end

  initial begin
    int t3v [9];
    t3v = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    T = '0; reset = 1'b1; pix_we = 1'b0; pix_addr = '0; pix_data = '0;
    k_we = 1'b0; k_addr = '0; k_data = '0; res_addr = '0;

    // Writes during reset must land.
    step(16'h0000, 1'b1);
    started = 1'b1;
    load(0, 1, 1, 1, 1, 1, 1'b1);
    step(16'h0000, 1'b0);

    // Test 1 with idle/multi-hot strobes inserted mid-window
    run_frame(1'b1, 1'b0);
    for (int a = 0; a < 9; a++) chk_res(a, 4);
    res_all();

    // Test 2: max values
    load(0, 15, 15, 15, 15, 15, 1'b0);
    run_frame(1'b0, 1'b0);
    for (int a = 0; a < 9; a++) chk_res(a, 900);

    // Test 5: test-3 setup, reset during T3 of window 4
    load(1, 0, 1, 0, 0, 0, 1'b0);
    compute_frame();
    step(16'h0001, 1'b0);
    for (int w = 0; w < 4; w++)
      for (int s = 1; s <= 7; s++) step(16'h0001 << s, 1'b0);
    step(16'h0002, 1'b0);
    step(16'h0004, 1'b0);
    step(16'h0008, 1'b1);
    chk("E_after_reset", 32'(E), 32'd0);
    chk("out_data_after_reset", 32'(out_data), 32'd0);
    for (int a = 0; a < 4; a++) chk_res(a, t3v[a]);
    for (int a = 4; a < 9; a++) chk_res(a, 900);
    step(16'h0000, 1'b0);

    // Test 3 (rerun after reset)
    run_frame(1'b0, 1'b0);
    for (int a = 0; a < 9; a++) chk_res(a, t3v[a]);
    for (int a = 9; a < 16; a++) chk_res(a, 0);
    res_all();

    // Test 6: write pixel 0 while window 0 is consuming it
    run_frame(1'b0, 1'b1);
    chk_res(0, 0);
    run_frame(1'b0, 1'b0);
    chk_res(0, 7);
    chk_res(4, 5);
    res_all();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
